// File: rtl/parallel_to_i2s.sv
// Parallel stereo sample to I2S serializer with a one-pair holding buffer.
// Generates BIT_CK/LR_CK from CLK and shifts each slot out MSB first with a one-bit delay.
module parallel_to_i2s #(
    parameter int WIDTH     = 16,
    parameter int SLOT_BITS = 32,
    parameter int CLK_DIV   = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA_L,
    input  logic [WIDTH-1:0] DATA_R,
    input  logic             VALID,
    output logic             READY,
    output logic             BIT_CK,
    output logic             LR_CK,
    output logic             DOUT,
    output logic             FRAME_START,
    output logic             UNDERRUN
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int B_W   = $clog2(SLOT_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [B_W-1:0]   B_LAST   = B_W'(SLOT_BITS - 1);
    localparam logic [B_W-1:0]   B_WIDTH  = B_W'(WIDTH);

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } slot_t;

    logic [DIV_W-1:0] div_q, div_d;
    logic             bit_ck_q, bit_ck_d;
    slot_t            slot_q, slot_d;
    logic [B_W-1:0]   bit_idx_q, bit_idx_d;
    logic             dout_q, dout_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             buf_full_q, buf_full_d;
    logic [WIDTH-1:0] buf_l_q, buf_l_d;
    logic [WIDTH-1:0] buf_r_q, buf_r_d;
    logic [WIDTH-1:0] work_l_q, work_l_d;
    logic [WIDTH-1:0] work_r_q, work_r_d;
    logic             ready_q, ready_d;
    logic             frame_start_q, frame_start_d;
    logic             underrun_q, underrun_d;

    logic div_tc;
    logic fall;
    logic accept;
    logic frame_load;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_q         <= '0;
            bit_ck_q      <= 1'b0;
            slot_q        <= SLOT_RIGHT;
            bit_idx_q     <= B_LAST;
            dout_q        <= 1'b0;
            shift_q       <= '0;
            buf_full_q    <= 1'b0;
            buf_l_q       <= '0;
            buf_r_q       <= '0;
            work_l_q      <= '0;
            work_r_q      <= '0;
            ready_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            div_q         <= div_d;
            bit_ck_q      <= bit_ck_d;
            slot_q        <= slot_d;
            bit_idx_q     <= bit_idx_d;
            dout_q        <= dout_d;
            shift_q       <= shift_d;
            buf_full_q    <= buf_full_d;
            buf_l_q       <= buf_l_d;
            buf_r_q       <= buf_r_d;
            work_l_q      <= work_l_d;
            work_r_q      <= work_r_d;
            ready_q       <= ready_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    always_comb begin
        div_d         = div_q;
        bit_ck_d      = bit_ck_q;
        slot_d        = slot_q;
        bit_idx_d     = bit_idx_q;
        dout_d        = dout_q;
        shift_d       = shift_q;
        buf_full_d    = buf_full_q;
        buf_l_d       = buf_l_q;
        buf_r_d       = buf_r_q;
        work_l_d      = work_l_q;
        work_r_d      = work_r_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        div_tc     = (div_q == DIV_LAST);
        fall       = div_tc && bit_ck_q;
        accept     = VALID && ready_q;
        frame_load = fall && (bit_idx_q == B_LAST) && (slot_q == SLOT_RIGHT);

        if (div_tc) begin
            div_d    = '0;
            bit_ck_d = ~bit_ck_q;
        end else begin
            div_d    = div_q + DIV_W'(1);
        end

        // The working pair only changes at a frame load; mid-frame offers go to the buffer.
        if (frame_load) begin
            frame_start_d = 1'b1;
            if (buf_full_q) begin
                work_l_d   = buf_l_q;
                work_r_d   = buf_r_q;
                buf_full_d = 1'b0;
            end else if (accept) begin
                work_l_d   = DATA_L;
                work_r_d   = DATA_R;
            end else begin
                work_l_d   = '0;
                work_r_d   = '0;
                underrun_d = 1'b1;
            end
        end else if (accept) begin
            buf_l_d    = DATA_L;
            buf_r_d    = DATA_R;
            buf_full_d = 1'b1;
        end

        ready_d = ~buf_full_d;

        // Index 0 of each slot is the I2S delay bit; the slot word is staged into the shifter there.
        if (fall) begin
            if (bit_idx_q == B_LAST) begin
                bit_idx_d = '0;
                dout_d    = 1'b0;
                if (slot_q == SLOT_RIGHT) begin
                    slot_d  = SLOT_LEFT;
                    shift_d = work_l_d;
                end else begin
                    slot_d  = SLOT_RIGHT;
                    shift_d = work_r_q;
                end
            end else begin
                bit_idx_d = bit_idx_q + B_W'(1);
                if (bit_idx_d <= B_WIDTH) begin
                    dout_d  = shift_q[WIDTH-1];
                    shift_d = shift_q << 1;
                end else begin
                    dout_d  = 1'b0;
                end
            end
        end
    end

    assign READY       = ready_q;
    assign BIT_CK      = bit_ck_q;
    assign LR_CK       = slot_q;
    assign DOUT        = dout_q;
    assign FRAME_START = frame_start_q;
    assign UNDERRUN    = underrun_q;

endmodule

// File: tb/tb_parallel_to_i2s.sv
// Self-checking bench for parallel_to_i2s: a time-indexed reference model predicts every output
// each CLK; scenario tasks add targeted constant checks for the fixed-pattern cases.
module tb_parallel_to_i2s;

    localparam int W  = 16;
    localparam int SB = 32;
    localparam int CD = 2;

    logic         CLK;
    logic         RESET;
    logic [W-1:0] DATA_L;
    logic [W-1:0] DATA_R;
    logic         VALID;
    logic         READY;
    logic         BIT_CK;
    logic         LR_CK;
    logic         DOUT;
    logic         FRAME_START;
    logic         UNDERRUN;

    parallel_to_i2s #(.WIDTH(W), .SLOT_BITS(SB), .CLK_DIV(CD)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .DATA_L     (DATA_L),
        .DATA_R     (DATA_R),
        .VALID      (VALID),
        .READY      (READY),
        .BIT_CK     (BIT_CK),
        .LR_CK      (LR_CK),
        .DOUT       (DOUT),
        .FRAME_START(FRAME_START),
        .UNDERRUN   (UNDERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Model state: k counts CLK edges since reset released; frame words are fixed at each load.
    int           k;
    logic         m_full, m_ready, m_fs, m_ur, m_acc;
    logic [W-1:0] m_buf_l, m_buf_r, m_cur_l, m_cur_r;

    function automatic logic [5:0] expected_outputs();
        int   n, b;
        logic bck, lr, d;
        logic [W-1:0] w;
        bck = ((k / CD) % 2) == 1;
        n   = k / (2 * CD);
        lr  = 1'b1;
        d   = 1'b0;
        if (n > 0) begin
            b  = (n - 1) % SB;
            lr = (((n - 1) / SB) % 2) == 1;
            w  = lr ? m_cur_r : m_cur_l;
            if (b >= 1 && b <= W) d = w[W - b];
        end
        return {bck, lr, d, m_ready, m_fs, m_ur};
    endfunction

    function automatic logic [5:0] observed();
        return {BIT_CK, LR_CK, DOUT, READY, FRAME_START, UNDERRUN};
    endfunction

    task automatic tick(input logic rst, input logic v, input logic [W-1:0] l, input logic [W-1:0] r);
        int   n;
        logic load;
        RESET  = rst;
        VALID  = v;
        DATA_L = l;
        DATA_R = r;
        @(posedge CLK);
        #1;
        if (rst) begin
            k = 0; m_full = 0; m_ready = 0; m_fs = 0; m_ur = 0; m_acc = 0;
            m_buf_l = '0; m_buf_r = '0; m_cur_l = '0; m_cur_r = '0;
        end else begin
            m_acc = v && m_ready;
            k++;
            n    = k / (2 * CD);
            load = (k % (2 * CD) == 0) && (((n - 1) % (2 * SB)) == 0);
            m_fs = load;
            m_ur = 1'b0;
            if (load) begin
                if (m_full) begin
                    m_cur_l = m_buf_l; m_cur_r = m_buf_r; m_full = 1'b0;
                end else if (m_acc) begin
                    m_cur_l = l; m_cur_r = r;
                end else begin
                    m_cur_l = '0; m_cur_r = '0; m_ur = 1'b1;
                end
            end else if (m_acc) begin
                m_buf_l = l; m_buf_r = r; m_full = 1'b1;
            end
            m_ready = !m_full;
        end
    endtask

    task automatic test_reset();
        logic [5:0] obs, exp_v;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
            obs = observed(); total++;
            if (obs !== 6'b010000) begin
                bad++; $display("[TB] FAIL reset_values got=%b want=%b", obs, 6'b010000);
            end
        end
        for (int i = 0; i < 24; i++) begin
            tick(1'b0, 1'b0, '0, '0);
            obs = observed(); exp_v = expected_outputs(); total++;
            if (obs !== exp_v) begin
                bad++; $display("[TB] FAIL reset_release k=%0d got=%b want=%b", k, obs, exp_v);
            end
            if (k == 1) begin
                total++;
                if (READY !== 1'b1) begin bad++; $display("[TB] FAIL ready_after_release got=%b want=1", READY); end
            end
            if (k == CD) begin
                total++;
                if (BIT_CK !== 1'b1) begin bad++; $display("[TB] FAIL first_bitck_rise got=%b want=1", BIT_CK); end
            end
            if (k == 2 * CD) begin
                total++;
                if ({FRAME_START, UNDERRUN, LR_CK} !== 3'b110) begin
                    bad++; $display("[TB] FAIL first_load got=%b want=110", {FRAME_START, UNDERRUN, LR_CK});
                end
            end
        end
    endtask

    task automatic test_known_pair();
        logic [5:0]  obs, exp_v;
        logic [63:0] bits, lrs;
        logic [W-1:0] left, right;
        logic        prev, accepted, others;
        int          rise, urs;
        tick(1'b1, 1'b0, '0, '0);
        tick(1'b1, 1'b0, '0, '0);
        bits = '0; lrs = '0; prev = BIT_CK; rise = 0; accepted = 0; urs = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1'b0, !accepted, 16'hA5C3, 16'h0F01);
            if (m_acc) accepted = 1'b1;
            obs = observed(); exp_v = expected_outputs(); total++;
            if (obs !== exp_v) begin
                bad++; $display("[TB] FAIL known_pair k=%0d got=%b want=%b", k, obs, exp_v);
            end
            if (k <= 4 * SB * CD && UNDERRUN === 1'b1) urs++;
            if (prev === 1'b0 && BIT_CK === 1'b1) begin
                rise++;
                if (rise >= 2 && rise <= 65) begin
                    bits[rise - 2] = DOUT;
                    lrs[rise - 2]  = LR_CK;
                end
            end
            prev = BIT_CK;
        end
        left = '0; right = '0; others = 1'b0;
        for (int b = 0; b < 64; b++) begin
            if (b >= 1 && b <= 16)       left  = {left[W-2:0], bits[b]};
            else if (b >= 33 && b <= 48) right = {right[W-2:0], bits[b]};
            else                         others = others | bits[b];
        end
        total++;
        if (left !== 16'hA5C3) begin bad++; $display("[TB] FAIL left_word got=%h want=a5c3", left); end
        total++;
        if (right !== 16'h0F01) begin bad++; $display("[TB] FAIL right_word got=%h want=0f01", right); end
        total++;
        if (others !== 1'b0) begin bad++; $display("[TB] FAIL pad_bits got=%b want=0", others); end
        total++;
        if (lrs !== {32'hFFFF_FFFF, 32'h0}) begin bad++; $display("[TB] FAIL lr_pattern got=%h want=ffffffff00000000", lrs); end
        total++;
        if (urs !== 0) begin bad++; $display("[TB] FAIL known_pair_underrun got=%0d want=0", urs); end
    endtask

    task automatic test_underrun();
        logic [5:0] obs, exp_v;
        int urs, fss;
        tick(1'b1, 1'b0, '0, '0);
        urs = 0; fss = 0;
        for (int i = 0; i < 700; i++) begin
            tick(1'b0, 1'b0, W'($urandom), W'($urandom));
            obs = observed(); exp_v = expected_outputs(); total++;
            if (obs !== exp_v) begin
                bad++; $display("[TB] FAIL underrun k=%0d got=%b want=%b", k, obs, exp_v);
            end
            if (UNDERRUN === 1'b1) urs++;
            if (FRAME_START === 1'b1) fss++;
        end
        total++;
        if (urs !== 3 || fss !== 3) begin
            bad++; $display("[TB] FAIL underrun_count got=%0d/%0d want=3/3", urs, fss);
        end
    endtask

    task automatic test_bypass();
        logic [5:0] obs, exp_v;
        logic [W-1:0] l, r;
        tick(1'b1, 1'b0, '0, '0);
        l = W'($urandom); r = W'($urandom);
        for (int i = 0; i < 520; i++) begin
            tick(1'b0, (k == 259), l, r);
            obs = observed(); exp_v = expected_outputs(); total++;
            if (obs !== exp_v) begin
                bad++; $display("[TB] FAIL bypass k=%0d got=%b want=%b", k, obs, exp_v);
            end
            if (k == 260) begin
                total++;
                if ({READY, FRAME_START, UNDERRUN} !== 3'b110) begin
                    bad++; $display("[TB] FAIL bypass_flags got=%b want=110", {READY, FRAME_START, UNDERRUN});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] obs, exp_v;
        logic [W-1:0] cnt;
        logic prev_rdy;
        int drops, urs;
        tick(1'b1, 1'b0, '0, '0);
        cnt = 16'h0100; drops = 0; urs = 0; prev_rdy = READY;
        for (int i = 0; i < 1280; i++) begin
            tick(1'b0, 1'b1, cnt, ~cnt);
            if (m_acc) cnt = cnt + 1'b1;
            obs = observed(); exp_v = expected_outputs(); total++;
            if (obs !== exp_v) begin
                bad++; $display("[TB] FAIL back_to_back k=%0d got=%b want=%b", k, obs, exp_v);
            end
            if (prev_rdy === 1'b1 && READY === 1'b0) drops++;
            if (UNDERRUN === 1'b1) urs++;
            prev_rdy = READY;
        end
        total++;
        if (drops !== 6 || urs !== 0) begin
            bad++; $display("[TB] FAIL accept_count got=%0d/%0d want=6/0", drops, urs);
        end
    endtask

    task automatic test_mid_reset();
        logic [5:0] obs, exp_v;
        logic [W-1:0] cnt;
        int n;
        logic found;
        tick(1'b1, 1'b0, '0, '0);
        cnt = 16'h3000; found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            tick(1'b0, 1'b1, cnt, cnt ^ 16'h5555);
            if (m_acc) cnt = cnt + 1'b1;
            n = k / (2 * CD);
            if (n > 0 && (k % (2 * CD)) == 0 && ((n - 1) % (2 * SB)) == SB + 8) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("[TB] FAIL mid_reset_reach got=0 want=1"); end
        total++;
        if ({LR_CK, DOUT} === 2'b10 && BIT_CK === 1'b0) begin end
        else if (LR_CK !== 1'b1) begin bad++; $display("[TB] FAIL mid_reset_slot got=%b want=1", LR_CK); end
        tick(1'b1, 1'b1, cnt, cnt);
        total++;
        if ({BIT_CK, LR_CK, DOUT, READY} !== 4'b0100) begin
            bad++; $display("[TB] FAIL mid_reset_values got=%b want=0100", {BIT_CK, LR_CK, DOUT, READY});
        end
        for (int i = 0; i < 300; i++) begin
            tick(1'b0, 1'b0, '0, '0);
            obs = observed(); exp_v = expected_outputs(); total++;
            if (obs !== exp_v) begin
                bad++; $display("[TB] FAIL mid_reset k=%0d got=%b want=%b", k, obs, exp_v);
            end
            if (k == 1) begin
                total++;
                if (READY !== 1'b1) begin bad++; $display("[TB] FAIL mid_reset_ready got=%b want=1", READY); end
            end
            if (k == 4) begin
                total++;
                if ({FRAME_START, LR_CK} !== 2'b10) begin
                    bad++; $display("[TB] FAIL mid_reset_frame got=%b want=10", {FRAME_START, LR_CK});
                end
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] obs, exp_v;
        tick(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 1100; i++) begin
            tick(1'b0, ($urandom_range(0, 39) == 0), W'($urandom), W'($urandom));
            obs = observed(); exp_v = expected_outputs(); total++;
            if (obs !== exp_v) begin
                bad++; $display("[TB] FAIL random k=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
    endtask

    initial begin
        RESET = 1'b1; VALID = 1'b0; DATA_L = '0; DATA_R = '0;
        test_reset();
        test_known_pair();
        test_underrun();
        test_bypass();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parallel_to_i2s.md
PARALLEL_TO_I2S -- requirements
Module: parallel_to_i2s

Interface
REQ-001 Parameter WIDTH, default 16, sample width per channel in bits.
REQ-002 Parameter SLOT_BITS, default 32, BIT_CK periods per channel slot; SHALL satisfy SLOT_BITS >= WIDTH+2.
REQ-003 Parameter CLK_DIV, default 2, CLK cycles per BIT_CK half-period; SHALL satisfy CLK_DIV >= 1.
REQ-004 CLK  input  1  system clock; all logic on posedge CLK.
REQ-005 RESET  input  1  reset RESET, synchronous, active-high.
REQ-006 DATA_L  input  WIDTH  left sample, two's complement, MSB first on wire.
REQ-007 DATA_R  input  WIDTH  right sample.
REQ-008 VALID  input  1  DATA_L/DATA_R pair offered.
REQ-009 READY  output  1  holding buffer empty; pair accepted on a CLK edge with VALID && READY.
REQ-010 BIT_CK  output  1  generated I2S bit clock, registered.
REQ-011 LR_CK  output  1  word select: 0 = left slot, 1 = right slot, registered.
REQ-012 DOUT  output  1  serial data, registered.
REQ-013 FRAME_START  output  1  one-CLK pulse when a left slot begins.
REQ-014 UNDERRUN  output  1  one-CLK pulse when a left slot begins with no pair available.

Function
REQ-015 Divider counts 0..CLK_DIV-1; at terminal count BIT_CK SHALL toggle and the counter SHALL wrap to 0; BIT_CK period = 2*CLK_DIV CLKs, 50% duty.
REQ-016 LR_CK and DOUT SHALL change only on the CLK edge where BIT_CK goes 1->0 (falling event); they are stable across every BIT_CK rise.
REQ-017 Bit index b counts 0..SLOT_BITS-1, advancing on each falling event; at wrap LR_CK SHALL toggle on the same edge that b becomes 0.
REQ-018 DOUT at index b: b=0 -> 0; 1<=b<=WIDTH -> word bit [WIDTH-b] (MSB at b=1, one-bit I2S delay); b>WIDTH -> 0.
REQ-019 Left slot uses the working left word; right slot uses the working right word.
REQ-020 Holding buffer: one DATA_L/DATA_R pair; READY = 1 when empty; acceptance fills it, READY SHALL drop on the next CLK.
REQ-021 Frame load: on the falling event where LR_CK goes 1->0, a full buffer SHALL be copied to the working pair and emptied (READY = 1 next CLK); FRAME_START pulses.
REQ-022 Bypass: if the buffer is empty and VALID is high on the frame-load edge, the offered pair SHALL load directly into the working pair, buffer stays empty, no UNDERRUN.
REQ-023 Underrun: buffer empty and VALID low on the frame-load edge -> working pair SHALL be zeroed and UNDERRUN SHALL pulse with FRAME_START.
REQ-024 Acceptance on a non-load edge while the buffer is empty SHALL not alter the working pair mid-frame.
REQ-025 Latency: a pair accepted before a frame-load edge appears in that frame; MSB of left on DOUT one BIT_CK after LR_CK falls.

Reset
REQ-026 During RESET: BIT_CK=0, LR_CK=1, DOUT=0, READY=0, FRAME_START=0, UNDERRUN=0, divider=0, b=SLOT_BITS-1, buffer empty, working pair zero.
REQ-027 First CLK after RESET deasserts, READY SHALL be 1; first BIT_CK rise after CLK_DIV CLKs, first falling event (first frame load) after 2*CLK_DIV CLKs.
REQ-028 RESET asserted mid-frame SHALL abandon the frame and discard the buffered pair; REQ-026 values appear on the next CLK edge.

Verification (WIDTH=16, SLOT_BITS=32, CLK_DIV=2: BIT_CK period 4 CLKs, frame 256 CLKs)
REQ-029 Offer L=0xA5C3, R=0x0F01 before first load -> LR_CK low 128 CLKs then high 128; DOUT bits b=1..16 of left = 1010010111000011, of right = 0000111100000001, all other bits 0; no UNDERRUN.
REQ-030 No VALID ever after reset -> UNDERRUN and FRAME_START pulse every 256 CLKs, DOUT constant 0, BIT_CK/LR_CK keep running.
REQ-031 VALID asserted exactly on a frame-load edge with buffer empty -> pair transmitted in that frame, READY stays 1, no UNDERRUN.
REQ-032 Hold VALID high with incrementing pairs -> exactly one acceptance per frame, READY low between acceptance and next load, each pair sent once in order.
REQ-033 RESET for 1 CLK at b=8 of a right slot -> next CLK BIT_CK=0, LR_CK=1, DOUT=0, READY=0; READY=1 one CLK after release; new frame starts 4 CLKs after release.
REQ-034 Loopback into the in-house I2S receiver (same WIDTH) -> its DATA_L/DATA_R equal the transmitted pair one frame later; its STROBE asserts each slot.
